// File: rtl/ms_alarm.sv
// ms_alarm: software-armed millisecond down-counter alarm with one-shot/periodic modes,
// a sticky expiry flag and a level interrupt.
module ms_alarm #(
   parameter int cnt_width = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ms_tick,
   input  logic        stb,
   input  logic        we,
   input  logic        addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        ack,
   output logic        expire,
   output logic        irq
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [cnt_width-1:0] reload_q, reload_d, cnt_q, cnt_d;
   logic en_q, en_d, periodic_q, periodic_d, irq_en_q, irq_en_d, expired_q, expired_d;
   logic cnt_wr, ctl_wr, stop, running, tick_ok, hit, dec;
   logic unused_bits;
   assign unused_bits = ^data_in;
   assign cnt_wr   = stb & we & ~addr;
   assign ctl_wr   = stb & we & addr;
   assign stop     = ctl_wr & ~data_in[0];
   assign running  = (state_q == RUN);
   // a COUNT write or a disabling CTRL write in the same cycle pre-empts the tick
   assign tick_ok  = running & ms_tick & ~cnt_wr & ~stop;
   assign hit      = tick_ok & (cnt_q == cnt_width'(1));
   assign dec      = tick_ok & (cnt_q > cnt_width'(1));
   assign expire   = hit;
   assign irq      = expired_q & irq_en_q;
   assign ack      = stb;
   assign data_out = (stb & ~we) ? (addr ? {27'b0, running, expired_q, irq_en_q, periodic_q, en_q}
                                         : 32'(cnt_q)) : 32'b0;
   always_comb begin
      state_d    = state_q;
      reload_d   = reload_q;
      cnt_d      = cnt_q;
      en_d       = en_q;
      periodic_d = periodic_q;
      irq_en_d   = irq_en_q;
      if (cnt_wr) begin
         reload_d = data_in[cnt_width-1:0];
         cnt_d    = data_in[cnt_width-1:0];
      end
      if (ctl_wr) begin
         periodic_d = data_in[1];
         irq_en_d   = data_in[2];
         if (!data_in[0]) begin
            en_d    = 1'b0;
            state_d = IDLE;
         end else if (reload_q == '0) begin
            en_d = 1'b0;
         end else begin
            en_d = 1'b1;
            if (!running) begin
               state_d = RUN;
               cnt_d   = reload_q;
            end
         end
      end
      if (dec) cnt_d = cnt_q - cnt_width'(1);
      // expiry runs after the CTRL decode so a one-shot finish overrides a concurrent en=1
      if (hit) begin
         cnt_d = periodic_q ? reload_q : '0;
         if (!periodic_q) begin
            en_d    = 1'b0;
            state_d = DONE;
         end
      end
      expired_d = hit | (expired_q & ~(ctl_wr & data_in[3]));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         reload_q   <= '0;
         cnt_q      <= '0;
         en_q       <= 1'b0;
         periodic_q <= 1'b0;
         irq_en_q   <= 1'b0;
         expired_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         reload_q   <= reload_d;
         cnt_q      <= cnt_d;
         en_q       <= en_d;
         periodic_q <= periodic_d;
         irq_en_q   <= irq_en_d;
         expired_q  <= expired_d;
      end
   end
endmodule

// File: tb/tb_ms_alarm.sv
// tb_ms_alarm: directed scenarios plus randomized bus/tick traffic against a
// behavioural alarm model.
module tb_ms_alarm;
   localparam logic [31:0] MASK = 32'h00FF_FFFF;
   logic clk = 1'b0, rst_n = 1'b0, ms_tick = 1'b0, stb = 1'b0, we = 1'b0, addr = 1'b0;
   logic [31:0] data_in = '0;
   logic [31:0] data_out;
   logic ack, expire, irq;
   int checks = 0, errors = 0;
   // model: mode 0 = stopped, 1 = counting, 2 = finished
   int unsigned m_rel, m_cnt;
   int m_mode;
   bit m_en, m_per, m_ie, m_exp;
   logic [31:0] s_do;
   logic s_exp;
   ms_alarm dut (
      .clk(clk), .rst_n(rst_n), .ms_tick(ms_tick), .stb(stb), .we(we), .addr(addr),
      .data_in(data_in), .data_out(data_out), .ack(ack), .expire(expire), .irq(irq)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic logic [31:0] m_ctrl();
      return {27'b0, m_mode == 1, m_exp, m_ie, m_per, m_en};
   endfunction
   task automatic m_reset();
      m_rel = 0; m_cnt = 0; m_mode = 0;
      m_en = 0; m_per = 0; m_ie = 0; m_exp = 0;
   endtask
   task automatic cyc(input bit s, input bit w, input bit a, input logic [31:0] d, input bit t);
      bit cw, cc, live, hit, dec, per0;
      logic [31:0] e_do;
      @(negedge clk);
      stb = s; we = w; addr = a; data_in = d; ms_tick = t;
      cw   = s && w && !a;
      cc   = s && w && a;
      live = (m_mode == 1) && t && !cw && !(cc && !d[0]);
      hit  = live && m_cnt == 1;
      dec  = live && m_cnt > 1;
      per0 = m_per;
      e_do = (s && !w) ? (a ? m_ctrl() : m_cnt) : 32'h0;
      #1;
      s_do = data_out; s_exp = expire;
      chk("ack", {31'b0, ack}, {31'b0, s});
      chk("data_out", data_out, e_do);
      chk("expire", {31'b0, expire}, {31'b0, hit});
      chk("irq", {31'b0, irq}, {31'b0, m_exp & m_ie});
      if (cw) begin m_rel = d & MASK; m_cnt = m_rel; end
      if (cc) begin
         m_per = d[1]; m_ie = d[2];
         if (d[3]) m_exp = 0;
         if (!d[0]) begin m_en = 0; m_mode = 0; end
         else if (m_rel == 0) m_en = 0;
         else begin
            m_en = 1;
            if (m_mode != 1) begin m_mode = 1; m_cnt = m_rel; end
         end
      end
      if (dec) m_cnt = m_cnt - 1;
      if (hit) begin
         m_exp = 1;
         if (per0) m_cnt = m_rel;
         else begin m_cnt = 0; m_en = 0; m_mode = 2; end
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      m_reset();
      #12;
      chk("rst_expire", {31'b0, expire}, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      chk("rst_data_out", data_out, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1, 0, 1, 0, 0); chk("rst_ctrl", s_do, 32'h0);
      cyc(1, 0, 0, 0, 0); chk("rst_count", s_do, 32'h0);
      // one-shot
      cyc(1, 1, 0, 3, 0);
      cyc(1, 1, 1, 5, 0);
      cyc(0, 0, 0, 0, 1); chk("os_t1", {31'b0, s_exp}, 32'h0);
      cyc(0, 0, 0, 0, 1); chk("os_t2", {31'b0, s_exp}, 32'h0);
      cyc(0, 0, 0, 0, 1); chk("os_t3", {31'b0, s_exp}, 32'h1);
      chk("os_irq", {31'b0, irq}, 32'h1);
      cyc(1, 0, 1, 0, 0); chk("os_ctrl", s_do, 32'h0C);
      cyc(1, 0, 0, 0, 0); chk("os_count", s_do, 32'h0);
      // periodic
      cyc(1, 1, 1, 32'h8, 0);
      cyc(1, 1, 0, 2, 0);
      cyc(1, 1, 1, 3, 0);
      for (int i = 1; i <= 6; i++) begin
         cyc(0, 0, 0, 0, 1);
         chk($sformatf("per_t%0d", i), {31'b0, s_exp}, {31'b0, i % 2 == 0});
      end
      cyc(1, 0, 0, 0, 0); chk("per_count", s_do, 32'h2);
      cyc(1, 0, 1, 0, 0); chk("per_ctrl", s_do, 32'h1B);
      // clear colliding with expiry, then a real clear
      cyc(0, 0, 0, 0, 1);
      cyc(1, 1, 1, 32'hF, 1); chk("clr_hit", {31'b0, s_exp}, 32'h1);
      cyc(1, 0, 1, 0, 0); chk("clr_set_wins", s_do & 32'h8, 32'h8);
      cyc(1, 1, 1, 32'hF, 0);
      cyc(1, 0, 1, 0, 0); chk("clr_done", s_do & 32'h8, 32'h0);
      chk("clr_irq", {31'b0, irq}, 32'h0);
      // zero-load guard
      cyc(1, 1, 1, 0, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 1, 1, 0);
      cyc(1, 0, 1, 0, 0); chk("zero_ctrl", s_do, 32'h0);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 0, 0, 1);
         chk("zero_noexp", {31'b0, s_exp}, 32'h0);
      end
      // COUNT write colliding with the final tick
      cyc(1, 1, 0, 1, 0);
      cyc(1, 1, 1, 1, 0);
      cyc(1, 1, 0, 5, 1); chk("coll_noexp", {31'b0, s_exp}, 32'h0);
      cyc(1, 0, 0, 0, 0); chk("coll_count", s_do, 32'h5);
      // reset mid-countdown
      cyc(1, 1, 0, 4, 0);
      cyc(1, 1, 1, 32'h5, 0);
      cyc(0, 0, 0, 0, 1);
      @(negedge clk);
      stb = 1'b0; ms_tick = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("mid_expire", {31'b0, expire}, 32'h0);
      chk("mid_irq", {31'b0, irq}, 32'h0);
      chk("mid_ack", {31'b0, ack}, 32'h0);
      chk("mid_data_out", data_out, 32'h0);
      #1 rst_n = 1'b1;
      m_reset();
      cyc(1, 0, 1, 0, 0); chk("mid_ctrl", s_do, 32'h0);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, 0, 0, 1);
         chk("mid_noexp", {31'b0, s_exp}, 32'h0);
      end
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit s, w, a, t;
         logic [31:0] d;
         s = $urandom_range(0, 9) < 4;
         w = $urandom_range(0, 3) != 0;
         a = $urandom_range(0, 1) == 1;
         t = $urandom_range(0, 1) == 1;
         d = a ? 32'($urandom_range(0, 15))
               : ($urandom_range(0, 19) == 0 ? 32'($urandom) : 32'($urandom_range(0, 4)));
         cyc(s, w, a, d, t);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ms_alarm.md
MS_ALARM -- requirements
Module: ms_alarm

Interface
REQ-001 SHALL provide parameter cnt_width, default 24: width of the reload register and the down-counter, legal range 1..32.
REQ-002 SHALL provide port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL provide port ms_tick  input  1  one-cycle millisecond strobe from the ms timer.
REQ-005 SHALL provide port stb  input  1  bus access strobe.
REQ-006 SHALL provide port we  input  1  write enable, qualified by stb.
REQ-007 SHALL provide port addr  input  1  register select: 0 = COUNT, 1 = CTRL.
REQ-008 SHALL provide port data_in  input  32  bus write data.
REQ-009 SHALL provide port data_out  output  32  bus read data.
REQ-010 SHALL provide port ack  output  1  bus acknowledge.
REQ-011 SHALL provide port expire  output  1  one-cycle pulse on each expiry.
REQ-012 SHALL provide port irq  output  1  level interrupt request.

Function
REQ-013 SHALL drive ack = stb combinationally; every access completes in the strobe cycle, with no wait states.
REQ-014 SHALL drive data_out to zero unless stb & ~we; reads SHALL have no side effects.
REQ-015 SHALL, on a COUNT write, load data_in[cnt_width-1:0] into both the reload register and the counter on the same edge.
REQ-016 SHALL return the current counter, zero-extended to 32 bits, on a COUNT read.
REQ-017 SHALL, on a CTRL write, update bit0 en, bit1 periodic and bit2 irq_en; writing bit3 = 1 clears the expired flag.
REQ-018 SHALL return CTRL reads as {27'b0, running, expired, irq_en, periodic, en}.
REQ-019 SHALL implement a state machine with states IDLE, RUN and DONE; running = (state == RUN).
REQ-020 SHALL move IDLE/DONE -> RUN on a CTRL write with en = 1 and reload != 0, loading counter <= reload.
REQ-021 SHALL ignore a CTRL write with en = 1 when reload == 0: en reads back 0 and the state is unchanged.
REQ-022 SHALL move any state -> IDLE on a CTRL write with en = 0, holding the counter value.
REQ-023 SHALL, in RUN, decrement the counter by 1 on each ms_tick while the counter > 1.
REQ-024 SHALL, in RUN, on ms_tick with counter == 1: set expired, pulse expire for exactly that cycle, and then:
  - if periodic: counter <= reload, stay in RUN (no lost or extra ms);
  - if not periodic: counter <= 0, en <= 0, go to DONE.
REQ-025 SHALL, when a COUNT write and an ms_tick coincide in RUN, let the write win: counter = new value, no decrement, no expiry.
REQ-026 SHALL, when an expiry and a clear of expired coincide, leave expired set (set wins).
REQ-027 SHALL keep expired sticky until cleared by software or reset.
REQ-028 SHALL drive irq = expired & irq_en, registered-state based with no combinational path from the bus.
REQ-029 SHALL ignore ms_tick in IDLE and DONE; the counter does not wrap below 0.

Reset
REQ-030 SHALL, while rst_n = 0, asynchronously force:
  - state = IDLE;
  - reload, counter, en, periodic, irq_en, expired = 0;
  - expire = 0, irq = 0.
REQ-031 SHALL abort any countdown when reset is asserted mid-operation; after release the block stays in IDLE until re-armed by software.
REQ-032 SHALL NOT gate ack or data_out by reset; both remain purely functions of stb, we and register state.

Verification
REQ-033 SHALL verify one-shot: COUNT = 3, CTRL = 0x5, then 3 ms_ticks -> expire pulses on tick 3, irq = 1, CTRL reads 0x0C, COUNT reads 0.
REQ-034 SHALL verify periodic: COUNT = 2, CTRL = 0x3, then 6 ms_ticks -> expire on ticks 2, 4 and 6, running stays 1, COUNT reads 2 after tick 6.
REQ-035 SHALL verify clear precedence: write CTRL bit3 = 1 in the same cycle as an expiry -> expired remains 1; a clear one cycle later -> expired = 0, irq = 0.
REQ-036 SHALL verify the zero-load guard: COUNT = 0, CTRL = 0x1 -> CTRL reads 0x00 and no expire for 10 ms_ticks.
REQ-037 SHALL verify write/tick collision: in RUN with counter = 1, COUNT = 5 written together with ms_tick -> no expire and COUNT reads 5.
REQ-038 SHALL verify reset mid-operation: in RUN with counter = 4, pulse rst_n low between edges -> all outputs 0 immediately, CTRL reads 0 and later ms_ticks produce no expire.
